// File: rtl/ghash_sequencer.sv
// ghash_sequencer: GHASH accumulate-and-multiply controller sitting in front of
// split_multiplier. Forms X = block ^ Z, streams X and the key H to the
// multiplier as flush + four key slices, captures the product back into Z,
// and emits Z as the tag after the last block of a message.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   h_i, h_valid_i           hash key and load strobe (IDLE only)
//   blk_i, blk_valid_i,
//   blk_last_i, blk_ready_o  input block handshake
//   mul_flush_o, mul_h*_o,
//   mul_a_o, mul_i           split_multiplier drive / product return
//   tag_o, tag_valid_o       GHASH tag and one-cycle update pulse
module ghash_sequencer #(
  parameter int unsigned DATA__WIDTH = 128,
  parameter int unsigned SPLIT_WIDTH = 32,
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA__WIDTH-1:0] h_i,
  input  logic                   h_valid_i,
  input  logic [DATA__WIDTH-1:0] blk_i,
  input  logic                   blk_valid_i,
  input  logic                   blk_last_i,
  output logic                   blk_ready_o,
  output logic                   mul_flush_o,
  output logic [SPLIT_WIDTH-1:0] mul_ha_o,
  output logic [SPLIT_WIDTH-1:0] mul_hb_o,
  output logic [SPLIT_WIDTH-1:0] mul_hc_o,
  output logic [SPLIT_WIDTH-1:0] mul_hd_o,
  output logic [DATA__WIDTH-1:0] mul_a_o,
  input  logic [DATA__WIDTH-1:0] mul_i,
  output logic [DATA__WIDTH-1:0] tag_o,
  output logic                   tag_valid_o
);

  localparam int unsigned WAIT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FLUSH, ST_SA, ST_SB, ST_SC, ST_SD, ST_WAIT
  } state_e;

  state_e                   state_q, state_d;
  logic [DATA__WIDTH-1:0]   h_q, h_d;
  logic                     key_loaded_q, key_loaded_d;
  logic [DATA__WIDTH-1:0]   z_q, z_d;
  logic [DATA__WIDTH-1:0]   x_q, x_d;
  logic                     last_q, last_d;
  logic [WAIT_W-1:0]        wait_q, wait_d;
  logic                     rdy_q, rdy_d;
  logic                     flush_q, flush_d;
  logic [SPLIT_WIDTH-1:0]   ha_q, ha_d, hb_q, hb_d, hc_q, hc_d, hd_q, hd_d;
  logic [DATA__WIDTH-1:0]   a_q, a_d;
  logic [DATA__WIDTH-1:0]   tag_q, tag_d;
  logic                     tag_valid_q, tag_valid_d;
  logic                     blk_fire;

  // Ready is registered; a same-cycle key load masks it so a load never
  // coincides with an accepted block.
  assign blk_ready_o = rdy_q & ~h_valid_i;
  assign blk_fire    = blk_ready_o & blk_valid_i;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    key_loaded_d = key_loaded_q;
    z_d          = z_q;
    x_d          = x_q;
    last_d       = last_q;
    wait_d       = wait_q;
    tag_d        = tag_q;
    tag_valid_d  = 1'b0;
    flush_d      = 1'b0;
    ha_d         = '0;
    hb_d         = '0;
    hc_d         = '0;
    hd_d         = '0;
    a_d          = '0;

    case (state_q)
      ST_IDLE: begin
        if (h_valid_i) begin
          h_d          = h_i;
          key_loaded_d = 1'b1;
        end else if (blk_fire) begin
          x_d     = blk_i ^ z_q;
          last_d  = blk_last_i;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_SA;
      ST_SA:    state_d = ST_SB;
      ST_SB:    state_d = ST_SC;
      ST_SC:    state_d = ST_SD;
      ST_SD: begin
        state_d = ST_WAIT;
        wait_d  = WAIT_W'(MUL_LATENCY - 1);
      end
      ST_WAIT: begin
        if (wait_q == '0) begin
          state_d = ST_IDLE;
          if (last_q) begin
            tag_d       = mul_i;
            tag_valid_d = 1'b1;
            z_d         = '0;
          end else begin
            z_d = mul_i;
          end
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    rdy_d   = (state_d == ST_IDLE) & key_loaded_d;
    flush_d = (state_d == ST_FLUSH);
    if (state_d == ST_SA) begin
      a_d  = x_q;
      ha_d = h_q[DATA__WIDTH-1 -: SPLIT_WIDTH];
    end
    if (state_d == ST_SB) hb_d = h_q[DATA__WIDTH-SPLIT_WIDTH-1 -: SPLIT_WIDTH];
    if (state_d == ST_SC) hc_d = h_q[2*SPLIT_WIDTH-1 -: SPLIT_WIDTH];
    if (state_d == ST_SD) hd_d = h_q[SPLIT_WIDTH-1:0];
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      h_q          <= '0;
      key_loaded_q <= 1'b0;
      z_q          <= '0;
      x_q          <= '0;
      last_q       <= 1'b0;
      wait_q       <= '0;
      rdy_q        <= 1'b0;
      flush_q      <= 1'b0;
      ha_q         <= '0;
      hb_q         <= '0;
      hc_q         <= '0;
      hd_q         <= '0;
      a_q          <= '0;
      tag_q        <= '0;
      tag_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      key_loaded_q <= key_loaded_d;
      z_q          <= z_d;
      x_q          <= x_d;
      last_q       <= last_d;
      wait_q       <= wait_d;
      rdy_q        <= rdy_d;
      flush_q      <= flush_d;
      ha_q         <= ha_d;
      hb_q         <= hb_d;
      hc_q         <= hc_d;
      hd_q         <= hd_d;
      a_q          <= a_d;
      tag_q        <= tag_d;
      tag_valid_q  <= tag_valid_d;
    end
  end

  assign mul_flush_o = flush_q;
  assign mul_ha_o    = ha_q;
  assign mul_hb_o    = hb_q;
  assign mul_hc_o    = hc_q;
  assign mul_hd_o    = hd_q;
  assign mul_a_o     = a_q;
  assign tag_o       = tag_q;
  assign tag_valid_o = tag_valid_q;

endmodule
